// File: rtl/irq_latch_ctrl.sv
`default_nettype none
// ==========================================================================
// irq_latch_ctrl : memory-mapped interrupt latch / acknowledge controller
// Option IRQ_CTRL_AUTOACK_EN: a VECTOR read acks the reported channel
// Revision: 1.0
// ==========================================================================
module irq_latch_ctrl #(
   parameter int         N_SRC    = 4,
   parameter int         NMI_CH   = 0,
   parameter logic [7:0] MASK_RST = 8'hFF,
   parameter logic [7:0] MODE_RST = 8'h00
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             ce,
   input  logic [N_SRC-1:0] src,
   input  logic             cs,
   input  logic             we,
   input  logic [2:0]       addr,
   input  logic [7:0]       din,
   output logic [7:0]       dout,
   output logic             irq,
   output logic             nmi,
   output logic [N_SRC-1:0] pending
);

   localparam logic [2:0] A_STATUS = 3'd0;
   localparam logic [2:0] A_MASK   = 3'd1;
   localparam logic [2:0] A_ACK    = 3'd2;
   localparam logic [2:0] A_MODE   = 3'd3;
   localparam logic [2:0] A_VECTOR = 3'd4;
   localparam logic [7:0] VALID    = 8'((16'd1 << N_SRC) - 16'd1);

   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] src_q, src_d;
   logic [7:0]       mask_q, mask_d;
   logic [7:0]       mode_q, mode_d;
   logic [7:0]       dout_q, dout_d;

   logic             wr_en, rd_en;
   logic [N_SRC-1:0] en_pend, nmi_bit, ack_clr, set_edge, set_lvl;
   logic             vec_any, vec_found;
   logic [2:0]       vec_idx;
   logic [7:0]       rd_data;

   always_comb begin
      wr_en   = ce & cs & we;
      rd_en   = ce & cs & ~we;
      nmi_bit = '0;
      nmi_bit[NMI_CH] = 1'b1;
      en_pend = pending_q & mask_q[N_SRC-1:0];
      vec_any = |en_pend;

      // Descending scan so the lowest-numbered channel wins
      vec_found = 1'b0;
      vec_idx   = 3'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (en_pend[i] && (i != NMI_CH)) begin
            vec_found = 1'b1;
            vec_idx   = 3'(i);
         end
      end

      rd_data = 8'h00;
      case (addr)
         A_STATUS: for (int i = 0; i < N_SRC; i++) rd_data[i] = pending_q[i];
         A_MASK:   rd_data = mask_q;
         A_MODE:   rd_data = mode_q;
         A_VECTOR: begin
            rd_data[7]   = vec_any;
            rd_data[2:0] = vec_idx;
         end
         default:  rd_data = 8'h00;
      endcase

      ack_clr = '0;
      if (wr_en && (addr == A_ACK)) ack_clr = din[N_SRC-1:0];
`ifdef IRQ_CTRL_AUTOACK_EN
      if (rd_en && (addr == A_VECTOR) && vec_found) begin
         for (int i = 0; i < N_SRC; i++)
            if (vec_idx == 3'(i)) ack_clr[i] = 1'b1;
      end
`endif

      // Edge sets always beat a clear; level sets are suppressed by it for one cycle
      set_edge  = src & ~src_q & ~mode_q[N_SRC-1:0];
      set_lvl   = src & mode_q[N_SRC-1:0] & ~ack_clr;
      pending_d = (pending_q & ~ack_clr) | set_edge | set_lvl;
      src_d     = src;

      mask_d = mask_q;
      mode_d = mode_q;
      if (wr_en && (addr == A_MASK)) mask_d = din & VALID;
      if (wr_en && (addr == A_MODE)) mode_d = din & VALID;

      dout_d = dout_q;
      if (ce) dout_d = rd_en ? rd_data : 8'h00;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         pending_q <= '0;
         src_q     <= '1;
         mask_q    <= MASK_RST & VALID;
         mode_q    <= MODE_RST & VALID;
         dout_q    <= 8'h00;
      end else begin
         pending_q <= pending_d;
         src_q     <= src_d;
         mask_q    <= mask_d;
         mode_q    <= mode_d;
         dout_q    <= dout_d;
      end
   end

   assign pending = pending_q;
   assign dout    = dout_q;
   assign nmi     = pending_q[NMI_CH] & mask_q[NMI_CH];
   assign irq     = |(pending_q & mask_q[N_SRC-1:0] & ~nmi_bit);

endmodule
`default_nettype wire

// File: tb/tb_irq_latch_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_irq_latch_ctrl : directed + random test against a behavioural model
// Revision: 1.0
// ==========================================================================
module tb_irq_latch_ctrl;

   localparam int N   = 4;
   localparam int NMI = 0;

   logic         clk_sys = 1'b0;
   logic         reset_n;
   logic         ce, cs, we;
   logic [N-1:0] src;
   logic [2:0]   addr;
   logic [7:0]   din;
   logic [7:0]   dout;
   logic         irq, nmi;
   logic [N-1:0] pending;

   irq_latch_ctrl #(
      .N_SRC(N), .NMI_CH(NMI), .MASK_RST(8'hFF), .MODE_RST(8'h00)
   ) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .src(src), .cs(cs),
      .we(we), .addr(addr), .din(din), .dout(dout), .irq(irq), .nmi(nmi),
      .pending(pending)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: one entry per channel
   bit         m_pend[N];
   bit         m_mask[N];
   bit         m_mode[N];
   bit         m_prev[N];
   logic [7:0] m_dout;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int lowest_irq();
      for (int i = 0; i < N; i++)
         if (i != NMI && m_pend[i] && m_mask[i]) return i;
      return -1;
   endfunction

   function automatic logic [7:0] model_read(input int a);
      int v;
      int k;
      bit any;
      v = 0;
      case (a)
         0: for (int i = 0; i < N; i++) v += m_pend[i] ? (1 << i) : 0;
         1: for (int i = 0; i < N; i++) v += m_mask[i] ? (1 << i) : 0;
         3: for (int i = 0; i < N; i++) v += m_mode[i] ? (1 << i) : 0;
         4: begin
            any = 1'b0;
            for (int i = 0; i < N; i++) if (m_pend[i] && m_mask[i]) any = 1'b1;
            k = lowest_irq();
            v = (any ? 128 : 0) + ((k >= 0) ? k : 0);
         end
         default: v = 0;
      endcase
      return 8'(v);
   endfunction

   task automatic compare_all();
      logic [N-1:0] ep;
      bit ei, en;
      ep = '0;
      ei = 1'b0;
      for (int i = 0; i < N; i++) begin
         ep[i] = m_pend[i];
         if (i != NMI && m_pend[i] && m_mask[i]) ei = 1'b1;
      end
      en = m_pend[NMI] && m_mask[NMI];
      check_val("pending", 32'(pending), 32'(ep));
      check_val("irq", 32'(irq), 32'(ei));
      check_val("nmi", 32'(nmi), 32'(en));
      check_val("dout", 32'(dout), 32'(m_dout));
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 1'b0;
         m_mask[i] = 1'b1;
         m_mode[i] = 1'b0;
         m_prev[i] = 1'b1;
      end
      m_dout = 8'h00;
   endtask

   // Advance one clock: predict from current inputs, then sample after the edge
   task automatic tick();
      logic [7:0] rv;
      int aa;
      bit ackbit;
      bit np[N];
      aa = -1;
      rv = 8'h00;
      if (ce && cs && !we) begin
         rv = model_read(int'(addr));
`ifdef IRQ_CTRL_AUTOACK_EN
         if (addr == 3'd4 && rv[7]) aa = lowest_irq();
`endif
      end
      for (int i = 0; i < N; i++) begin
         ackbit = (ce && cs && we && addr == 3'd2 && din[i]) || (aa == i);
         if (m_mode[i]) np[i] = (m_pend[i] || src[i]) && !ackbit;
         else           np[i] = (src[i] && !m_prev[i]) || (m_pend[i] && !ackbit);
      end
      for (int i = 0; i < N; i++) begin
         if (ce && cs && we && addr == 3'd1) m_mask[i] = din[i];
         if (ce && cs && we && addr == 3'd3) m_mode[i] = din[i];
         m_pend[i] = np[i];
         m_prev[i] = src[i];
      end
      if (ce) m_dout = rv;
      @(posedge clk_sys);
      #1;
      compare_all();
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      cs = 1'b1; we = 1'b1; ce = 1'b1; addr = a; din = d;
      tick();
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [7:0] v);
      cs = 1'b1; we = 1'b0; ce = 1'b1; addr = a;
      tick();
      v = dout;
      cs = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (2) begin
         @(posedge clk_sys);
         #1;
         compare_all();
      end
      reset_n = 1'b1;
   endtask

   logic [7:0] v, v1, v2, v3;

   initial begin
      ce = 1'b1; cs = 1'b0; we = 1'b0; addr = 3'd0; din = 8'h00;
      src = 4'b0001;

      // Reset with src[0] held high: no edge on release
      do_reset();
      check_val("rst_pending", 32'(pending), 32'h0);
      check_val("rst_irq", 32'(irq), 32'h0);
      check_val("rst_nmi", 32'(nmi), 32'h0);
      check_val("rst_dout", 32'(dout), 32'h0);
      tick();
      check_val("no_edge_nmi", 32'(nmi), 32'h0);
      src = 4'b0000; tick();
      src = 4'b0001; tick();
      check_val("nmi_rise", 32'(nmi), 32'h1);
      src = 4'b0000;
      wr(3'd2, 8'h01);
      check_val("nmi_ack", 32'(nmi), 32'h0);

      // Edge latch captured with ce low, then ACK
      ce = 1'b0; src = 4'b0100; tick();
      src = 4'b0000; ce = 1'b1;
      check_val("edge_pend", 32'(pending), 32'h4);
      check_val("edge_irq", 32'(irq), 32'h1);
      wr(3'd2, 8'h04);
      check_val("ack_irq", 32'(irq), 32'h0);
      rd(3'd0, v);
      check_val("ack_status", 32'(v), 32'h00);
      tick();
      check_val("dout_idle", 32'(dout), 32'h00);

      // Masked channel still latches
      wr(3'd1, 8'hFB);
      src = 4'b0100; tick();
      src = 4'b0000; tick();
      check_val("mask_irq", 32'(irq), 32'h0);
      rd(3'd0, v);
      check_val("mask_status", 32'(v), 32'h04);
      wr(3'd1, 8'hFF);
      check_val("unmask_irq", 32'(irq), 32'h1);
      rd(3'd1, v);
      check_val("mask_read", 32'(v), 32'h0F);
      wr(3'd2, 8'h04);

      // Level mode on channel 1
      wr(3'd3, 8'h02);
      src = 4'b0010; tick(); tick();
      check_val("lvl_set", 32'(pending[1]), 32'h1);
      wr(3'd2, 8'h02);
      check_val("lvl_ack", 32'(pending[1]), 32'h0);
      tick();
      check_val("lvl_reset", 32'(pending[1]), 32'h1);
      src = 4'b0000;
      wr(3'd2, 8'h02);
      check_val("lvl_rel_ack", 32'(pending[1]), 32'h0);
      tick();
      check_val("lvl_stays0", 32'(pending[1]), 32'h0);
      wr(3'd3, 8'h00);

      // Set/ACK collision on an edge channel
      src = 4'b1000;
      wr(3'd2, 8'h08);
      check_val("collide", 32'(pending[3]), 32'h1);
      src = 4'b0000;
      wr(3'd2, 8'h08);

      // Vector reads with channels 1 and 3 pending
      src = 4'b1010; tick();
      src = 4'b0000; tick();
      rd(3'd4, v1);
      rd(3'd4, v2);
      rd(3'd4, v3);
      check_val("vec1", 32'(v1), 32'h81);
`ifdef IRQ_CTRL_AUTOACK_EN
      check_val("vec2", 32'(v2), 32'h83);
      check_val("vec3", 32'(v3), 32'h00);
`else
      check_val("vec2", 32'(v2), 32'h81);
      check_val("vec3", 32'(v3), 32'h81);
`endif
      rd(3'd6, v);
      check_val("unused_addr", 32'(v), 32'h00);
      wr(3'd2, 8'hFF);

      // Random traffic against the model
      for (int n = 0; n < 1500; n++) begin
         src  = N'($urandom);
         ce   = ($urandom_range(0, 3) != 0);
         cs   = ($urandom_range(0, 2) == 0);
         we   = 1'($urandom);
         addr = 3'($urandom);
         din  = 8'($urandom);
         tick();
         if (n == 700) begin
            cs = 1'b0;
            do_reset();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
